// File: rtl/store_merge_unit.sv
// ---------------------------------------------------------------------------
// store_merge_unit
//
// Store-side companion of the load path. Takes one store request (byte
// address, register data, access size) and commits it to a data memory that
// only supports full-word writes. Word stores are written directly. Byte and
// halfword stores do a read-modify-write: read the containing word, merge the
// new lane into it, then write the merged word back.
//
// Parameters
//   TIMEOUT   cycles allowed in READ or WRITE without a memory handshake
//             before the request is aborted (0 disables the timeout)
//   TO_WIDTH  width of the timeout counter (TIMEOUT < 2**TO_WIDTH)
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   StoreReq         request strobe, only looked at while idle
//   StoreAddr        byte address of the store
//   StoreData        register data (byte: [7:0], half: [15:0], word: all)
//   StoreSelector    00 byte, 01 halfword, 10 word, 11 invalid
//   StoreBusy        high whenever the unit is not idle
//   StoreDone        one-cycle pulse, store committed to memory
//   StoreError       one-cycle pulse, request aborted without a write
//   StoreErrCode     00 none, 01 misaligned, 10 invalid size, 11 timeout;
//                    held until the next accepted request
//   MemAddr          word-aligned address, 0 while idle
//   MemRead          read request, held until MemRValid
//   MemRData         read data, qualified by MemRValid
//   MemRValid        read data valid
//   MemWrite         write request, held until MemWReady
//   MemWData         merged word to write, 0 outside WRITE
//   MemWReady        write accepted this cycle
// ---------------------------------------------------------------------------
module store_merge_unit #(
    parameter int TIMEOUT  = 16,
    parameter int TO_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        StoreReq,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] StoreData,
    input  logic [1:0]  StoreSelector,
    output logic        StoreBusy,
    output logic        StoreDone,
    output logic        StoreError,
    output logic [1:0]  StoreErrCode,

    output logic [31:0] MemAddr,
    output logic        MemRead,
    input  logic [31:0] MemRData,
    input  logic        MemRValid,
    output logic        MemWrite,
    output logic [31:0] MemWData,
    input  logic        MemWReady
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_BAD  = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Last counter value before the limit; the counter starts at 0 on entry,
    // so reaching TO_LAST without a handshake means TIMEOUT cycles elapsed.
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic                TO_ON   = (TIMEOUT > 0);

    state_t                state_q,  state_d;
    logic [31:0]           addr_q,   addr_d;
    logic [1:0]            sel_q,    sel_d;
    logic [31:0]           buf_q,    buf_d;
    logic [TO_WIDTH-1:0]   cnt_q,    cnt_d;
    logic [1:0]            code_q,   code_d;

    logic                  timeout_hit;
    logic                  misaligned;
    logic [31:0]           merged;

    assign timeout_hit = TO_ON && (cnt_q == TO_LAST);

    // Alignment check on the incoming request (bytes are always aligned).
    assign misaligned = ((StoreSelector == SEL_HALF) && StoreAddr[0]) ||
                        ((StoreSelector == SEL_WORD) && (StoreAddr[1:0] != 2'b00));

    // Merge the latched register lane into the word returned by memory.
    // Only byte and halfword requests ever reach READ, so anything that is
    // not a byte is treated as a halfword here.
    always_comb begin
        merged = MemRData;
        if (sel_q == SEL_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = buf_q[7:0];
                2'd1:    merged[15:8]  = buf_q[7:0];
                2'd2:    merged[23:16] = buf_q[7:0];
                default: merged[31:24] = buf_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = buf_q[15:0];
        end else begin
            merged[15:0]  = buf_q[15:0];
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so
        // no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                if (StoreReq) begin
                    addr_d = StoreAddr;
                    sel_d  = StoreSelector;
                    // Word stores write this directly; byte/half stores keep
                    // their lane here until the read data arrives.
                    buf_d  = StoreData;
                    cnt_d  = '0;
                    code_d = ERR_NONE;
                    if (StoreSelector == SEL_BAD) begin
                        state_d = S_ERR;
                        code_d  = ERR_SIZE;
                    end else if (misaligned) begin
                        state_d = S_ERR;
                        code_d  = ERR_MISALIGN;
                    end else if (StoreSelector == SEL_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                // A handshake in the same cycle the limit is reached wins.
                if (MemRValid) begin
                    buf_d   = merged;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = cnt_q + TO_WIDTH'(1);
                end
            end

            S_WRITE: begin
                if (MemWReady) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = cnt_q + TO_WIDTH'(1);
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Outputs are decoded purely from registered state, so they drop the
    // moment reset is asserted.
    assign StoreBusy    = (state_q != S_IDLE);
    assign StoreDone    = (state_q == S_DONE);
    assign StoreError   = (state_q == S_ERR);
    assign StoreErrCode = code_q;
    assign MemRead      = (state_q == S_READ);
    assign MemWrite     = (state_q == S_WRITE);
    assign MemAddr      = (state_q == S_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};
    assign MemWData     = (state_q == S_WRITE) ? buf_q : 32'h0;

endmodule

// File: tb/tb_store_merge_unit.sv
// ---------------------------------------------------------------------------
// tb_store_merge_unit
//
// Self-checking bench for store_merge_unit. Expected memory writes are
// pushed to a scoreboard queue when a store is issued and popped when the
// write handshake is seen. Inputs are driven and outputs sampled on the
// falling clock edge, away from the active edge.
// ---------------------------------------------------------------------------
module tb_store_merge_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        StoreReq;
    logic [31:0] StoreAddr;
    logic [31:0] StoreData;
    logic [1:0]  StoreSelector;
    logic        StoreBusy;
    logic        StoreDone;
    logic        StoreError;
    logic [1:0]  StoreErrCode;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic [31:0] MemRData;
    logic        MemRValid;
    logic        MemWrite;
    logic [31:0] MemWData;
    logic        MemWReady;

    store_merge_unit #(.TIMEOUT(TIMEOUT), .TO_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .StoreReq     (StoreReq),
        .StoreAddr    (StoreAddr),
        .StoreData    (StoreData),
        .StoreSelector(StoreSelector),
        .StoreBusy    (StoreBusy),
        .StoreDone    (StoreDone),
        .StoreError   (StoreError),
        .StoreErrCode (StoreErrCode),
        .MemAddr      (MemAddr),
        .MemRead      (MemRead),
        .MemRData     (MemRData),
        .MemRValid    (MemRValid),
        .MemWrite     (MemWrite),
        .MemWData     (MemWData),
        .MemWReady    (MemWReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  passed = 0;
    int  total  = 0;

    // Observations returned by run_store.
    int          o_lat;
    bit          o_done, o_err, o_read, o_write, o_stable, o_pulse_ok;
    logic [31:0] o_wdata, o_waddr;
    int          o_rcycles;
    logic [1:0]  o_code, o_first_code;

    // Reference merge: old word with the selected lane replaced by new data.
    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] addr,
                                              input logic [31:0] data, input logic [1:0] sel);
        logic [31:0] mask;
        int          sh;
        if (sel == 2'b10) return data;
        if (sel == 2'b00) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'h0000_00FF << sh;
            return (old_w & ~mask) | ((data & 32'h0000_00FF) << sh);
        end
        sh   = 16 * int'(addr[1]);
        mask = 32'h0000_FFFF << sh;
        return (old_w & ~mask) | ((data & 32'h0000_FFFF) << sh);
    endfunction

    // Issue one request and watch it until StoreDone/StoreError (bounded).
    // rvalid_after: MemRValid goes high after this many post-accept samples.
    // noise: keep StoreReq high with a different word request for 3 cycles.
    task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] sel, input int rvalid_after, input bit noise);
        bit seen_addr;
        seen_addr = 0;
        o_lat = 0; o_done = 0; o_err = 0; o_read = 0; o_write = 0; o_stable = 1;
        o_wdata = 'x; o_waddr = 'x; o_rcycles = 0; o_code = 'x; o_first_code = 'x;
        @(negedge clk);
        StoreReq = 1'b1; StoreAddr = addr; StoreData = data; StoreSelector = sel;
        MemRValid = (rvalid_after == 0);
        @(negedge clk);
        if (noise) begin
            StoreAddr = 32'h0000_0500; StoreData = 32'h5555_5555; StoreSelector = 2'b10;
        end else begin
            StoreReq = 1'b0;
        end
        for (int i = 0; i < 64; i++) begin
            o_lat++;
            if (o_lat == 1) o_first_code = StoreErrCode;
            if (MemRead || MemWrite) begin
                if (!seen_addr) begin o_waddr = MemAddr; seen_addr = 1; end
                else if (MemAddr !== o_waddr) o_stable = 0;
            end
            if (MemRead) begin o_read = 1; o_rcycles++; end
            if (MemWrite) begin
                o_write = 1;
                if (MemWReady) o_wdata = MemWData;
            end
            if (StoreDone) o_done = 1;
            if (StoreError) o_err = 1;
            if (o_done || o_err) begin o_code = StoreErrCode; break; end
            if (noise && o_lat == 3) StoreReq = 1'b0;
            if (o_lat >= rvalid_after) MemRValid = 1'b1;
            @(negedge clk);
        end
        StoreReq = 1'b0;
        @(negedge clk);
        o_pulse_ok = !StoreDone && !StoreError && !StoreBusy;
        MemRValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; StoreReq = 0; StoreAddr = 0; StoreData = 0; StoreSelector = 0;
        MemRData = 0; MemRValid = 0; MemWReady = 0;
        repeat (2) @(negedge clk);
        total++; if ({StoreBusy, StoreDone, StoreError, MemRead, MemWrite} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {StoreBusy, StoreDone, StoreError, MemRead, MemWrite}); else passed++;
        total++; if ({StoreErrCode, MemAddr, MemWData} !== 66'h0)
            $display("FAIL reset_data: code %b addr %h wdata %h expected zeros", StoreErrCode, MemAddr, MemWData); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (StoreBusy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", StoreBusy); else passed++;
    endtask

    task automatic test_word();
        wr_t e;
        MemWReady = 1'b1;
        exp_q.push_back('{addr: 32'h100, data: 32'hDEADBEEF});
        run_store(32'h100, 32'hDEADBEEF, 2'b10, 1000, 0);
        total++; if (o_done !== 1'b1 || o_err !== 1'b0) $display("FAIL word_done: done %b err %b expected 1 0", o_done, o_err); else passed++;
        total++; if (o_lat !== 2) $display("FAIL word_latency: got %0d expected 2", o_lat); else passed++;
        total++; if (o_read !== 1'b0) $display("FAIL word_no_read: got %b expected 0", o_read); else passed++;
        e = exp_q.pop_front();
        total++; if (o_wdata !== e.data) $display("FAIL word_wdata: got %h expected %h", o_wdata, e.data); else passed++;
        total++; if (o_waddr !== e.addr) $display("FAIL word_addr: got %h expected %h", o_waddr, e.addr); else passed++;
        total++; if (o_pulse_ok !== 1'b1) $display("FAIL word_pulse: got %b expected 1", o_pulse_ok); else passed++;
    endtask

    task automatic test_byte_rmw();
        wr_t e;
        MemWReady = 1'b1; MemRData = 32'h11223344;
        exp_q.push_back('{addr: 32'h200, data: 32'hAB223344});
        run_store(32'h203, 32'h000000AB, 2'b00, 0, 0);
        total++; if (o_done !== 1'b1) $display("FAIL byte_done: got %b expected 1", o_done); else passed++;
        total++; if (o_lat !== 3) $display("FAIL byte_latency: got %0d expected 3", o_lat); else passed++;
        total++; if (o_rcycles !== 1) $display("FAIL byte_read_cycles: got %0d expected 1", o_rcycles); else passed++;
        e = exp_q.pop_front();
        total++; if (o_wdata !== e.data) $display("FAIL byte_wdata: got %h expected %h", o_wdata, e.data); else passed++;
        total++; if (o_waddr !== e.addr || o_stable !== 1'b1)
            $display("FAIL byte_addr: got %h stable %b expected %h stable 1", o_waddr, o_stable, e.addr); else passed++;
    endtask

    task automatic test_half_rmw();
        wr_t e;
        MemWReady = 1'b1; MemRData = 32'h11223344;
        exp_q.push_back('{addr: 32'h300, data: 32'hCAFE3344});
        exp_q.push_back('{addr: 32'h300, data: 32'h1122CAFE});
        run_store(32'h302, 32'h0000CAFE, 2'b01, 0, 0);
        e = exp_q.pop_front();
        total++; if (o_done !== 1'b1 || o_wdata !== e.data)
            $display("FAIL half_hi: done %b wdata %h expected 1 %h", o_done, o_wdata, e.data); else passed++;
        run_store(32'h300, 32'h0000CAFE, 2'b01, 0, 0);
        e = exp_q.pop_front();
        total++; if (o_done !== 1'b1 || o_wdata !== e.data)
            $display("FAIL half_lo: done %b wdata %h expected 1 %h", o_done, o_wdata, e.data); else passed++;
        total++; if (o_lat !== 3) $display("FAIL half_latency: got %0d expected 3", o_lat); else passed++;
    endtask

    task automatic test_byte_lanes();
        wr_t         e;
        logic [31:0] a, d, old_w;
        for (int lane = 0; lane < 4; lane++) begin
            a = 32'h0000_1000 + 32'(lane * 4 + lane);   // word 0x1000+4*lane, byte lane 'lane'
            d = $urandom();
            old_w = $urandom();
            MemRData = old_w; MemWReady = 1'b1;
            exp_q.push_back('{addr: {a[31:2], 2'b00}, data: ref_merge(old_w, a, d, 2'b00)});
            run_store(a, d, 2'b00, 0, 0);
            e = exp_q.pop_front();
            total++; if (o_wdata !== e.data || o_waddr !== e.addr)
                $display("FAIL byte_lane%0d: wdata %h addr %h expected %h %h", lane, o_wdata, o_waddr, e.data, e.addr); else passed++;
        end
    endtask

    task automatic test_errors();
        MemWReady = 1'b1;
        run_store(32'h301, 32'h0000CAFE, 2'b01, 0, 0);
        total++; if (o_err !== 1'b1 || o_code !== 2'b01)
            $display("FAIL misalign_half: err %b code %b expected 1 01", o_err, o_code); else passed++;
        total++; if (o_read !== 1'b0 || o_write !== 1'b0)
            $display("FAIL misalign_nomem: read %b write %b expected 0 0", o_read, o_write); else passed++;
        total++; if (o_pulse_ok !== 1'b1 || StoreErrCode !== 2'b01)
            $display("FAIL misalign_hold: pulse_ok %b code %b expected 1 01", o_pulse_ok, StoreErrCode); else passed++;
        run_store(32'h102, 32'h12345678, 2'b10, 0, 0);
        total++; if (o_err !== 1'b1 || o_code !== 2'b01 || o_write !== 1'b0)
            $display("FAIL misalign_word: err %b code %b write %b expected 1 01 0", o_err, o_code, o_write); else passed++;
        run_store(32'h400, 32'h12345678, 2'b11, 0, 0);
        total++; if (o_err !== 1'b1 || o_code !== 2'b10)
            $display("FAIL invalid_size: err %b code %b expected 1 10", o_err, o_code); else passed++;
        total++; if (o_read !== 1'b0 || o_write !== 1'b0 || o_lat !== 1)
            $display("FAIL invalid_nomem: read %b write %b lat %0d expected 0 0 1", o_read, o_write, o_lat); else passed++;
    endtask

    task automatic test_timeout();
        MemWReady = 1'b1;
        run_store(32'h203, 32'h000000AB, 2'b00, 1000, 0);
        total++; if (o_err !== 1'b1 || o_code !== 2'b11)
            $display("FAIL timeout_err: err %b code %b expected 1 11", o_err, o_code); else passed++;
        total++; if (o_rcycles !== TIMEOUT) $display("FAIL timeout_cycles: got %0d expected %0d", o_rcycles, TIMEOUT); else passed++;
        total++; if (o_write !== 1'b0) $display("FAIL timeout_nowrite: got %b expected 0", o_write); else passed++;
        // A new accepted request clears the held code.
        exp_q.push_back('{addr: 32'h180, data: 32'h0BADF00D});
        run_store(32'h180, 32'h0BADF00D, 2'b10, 0, 0);
        total++; if (o_first_code !== 2'b00) $display("FAIL code_clear: got %b expected 00", o_first_code); else passed++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_handshake_at_limit();
        wr_t e;
        MemWReady = 1'b1; MemRData = 32'hA5A5A5A5;
        exp_q.push_back('{addr: 32'h700, data: ref_merge(32'hA5A5A5A5, 32'h702, 32'h0000BEEF, 2'b01)});
        run_store(32'h702, 32'h0000BEEF, 2'b01, TIMEOUT, 0);
        e = exp_q.pop_front();
        total++; if (o_done !== 1'b1 || o_err !== 1'b0)
            $display("FAIL limit_handshake: done %b err %b expected 1 0", o_done, o_err); else passed++;
        total++; if (o_wdata !== e.data || o_lat !== TIMEOUT + 2)
            $display("FAIL limit_data: wdata %h lat %0d expected %h %0d", o_wdata, o_lat, e.data, TIMEOUT + 2); else passed++;
    endtask

    task automatic test_busy_ignored();
        wr_t e;
        MemWReady = 1'b1; MemRData = 32'h0;
        exp_q.push_back('{addr: 32'h400, data: 32'hAB000000});
        run_store(32'h403, 32'h000000AB, 2'b00, 4, 1);
        e = exp_q.pop_front();
        total++; if (o_done !== 1'b1 || o_wdata !== e.data || o_waddr !== e.addr)
            $display("FAIL busy_ignore: done %b wdata %h addr %h expected 1 %h %h", o_done, o_wdata, o_waddr, e.data, e.addr); else passed++;
        total++; if (o_pulse_ok !== 1'b1 || o_stable !== 1'b1)
            $display("FAIL busy_no_queue: pulse_ok %b stable %b expected 1 1", o_pulse_ok, o_stable); else passed++;
    endtask

    task automatic test_reset_mid_write();
        wr_t e;
        MemWReady = 1'b0;
        @(negedge clk);
        StoreReq = 1'b1; StoreAddr = 32'h600; StoreData = 32'h600D600D; StoreSelector = 2'b10;
        @(negedge clk);
        StoreReq = 1'b0;
        total++; if (MemWrite !== 1'b1) $display("FAIL midwr_in_write: got %b expected 1", MemWrite); else passed++;
        #2 reset = 1'b1;
        #1;
        total++; if ({StoreBusy, StoreDone, StoreError, MemRead, MemWrite, StoreErrCode, MemAddr, MemWData} !== 71'h0)
            $display("FAIL midwr_reset: busy %b write %b addr %h wdata %h expected zeros", StoreBusy, MemWrite, MemAddr, MemWData); else passed++;
        @(negedge clk);
        reset = 1'b0;
        MemWReady = 1'b1;
        exp_q.push_back('{addr: 32'h100, data: 32'hDEADBEEF});
        run_store(32'h100, 32'hDEADBEEF, 2'b10, 1000, 0);
        e = exp_q.pop_front();
        total++; if (o_done !== 1'b1 || o_wdata !== e.data || o_lat !== 2)
            $display("FAIL midwr_recover: done %b wdata %h lat %0d expected 1 %h 2", o_done, o_wdata, o_lat, e.data); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half_rmw();
        test_byte_lanes();
        test_errors();
        test_timeout();
        test_handshake_at_limit();
        test_busy_ignored();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
